sd_in_ddr: RTL and testbench

DDR-to-SDR receiver for the srdy/drdy interface: the far-end counterpart of the DDR output block. It captures a half-width DDR bus, with the upper half valid while `clk` is high and the lower half valid while `clk` is low, and reassembles full-width words. Words are buffered in a small FIFO and presented on a standard SDR srdy/drdy producer interface. The `c_drdy` output is registered so the backpressure path across the DDR link has no combinational dependency on `p_drdy`.

---
 rtl/sd_in_ddr.sv | 88 ++++++++
 tb/tb_sd_in_ddr.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sd_in_ddr.sv
// DDR-to-SDR receiver: rebuilds full-width words from a half-width DDR bus and buffers them in a small FIFO.
// Optional macro SD_IN_DDR_CNT_EN adds a saturating 16-bit count of accepted words on word_cnt.
module sd_in_ddr #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               c_srdy,
  output logic               c_drdy,
  input  logic [width/2-1:0] c_data,
  output logic               p_srdy,
  input  logic               p_drdy,
  output logic [width-1:0]   p_data
`ifdef SD_IN_DDR_CNT_EN
  ,
  output logic [15:0]        word_cnt
`endif
);

  localparam int AW = $clog2(depth);

  logic [width/2-1:0] r_hi_cap;
  logic [width-1:0]   r_mem [depth];
  logic [AW:0]        r_wptr;
  logic [AW:0]        r_rptr;
  logic               r_c_drdy;

  logic [width-1:0]   w_word;
  logic [AW:0]        w_count;
  logic [AW+1:0]      w_count_next;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;

  // Upper half is stable while clk is high, so it is captured on the falling edge.
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) r_hi_cap <= '0;
    else          r_hi_cap <= c_data;
  end

  assign w_word  = {r_hi_cap, c_data};
  assign w_empty = (r_wptr == r_rptr);
  assign w_count = r_wptr - r_rptr;
  assign w_push  = c_srdy & r_c_drdy;
  assign w_pop   = ~w_empty & p_drdy;

  assign w_count_next = {1'b0, w_count}
                      + {{(AW+1){1'b0}}, w_push}
                      - {{(AW+1){1'b0}}, w_pop};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < depth; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= w_word;
    end
  end

  // Ready is computed from next-cycle occupancy so a push can never land on a full FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_c_drdy <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_c_drdy <= (w_count_next < (AW+2)'(depth));
    end
  end

  assign c_drdy = r_c_drdy;
  assign p_srdy = ~w_empty;
  assign p_data = r_mem[r_rptr[AW-1:0]];

`ifdef SD_IN_DDR_CNT_EN
  logic [15:0] r_word_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                             r_word_cnt <= '0;
    else if (w_push && r_word_cnt != 16'hFFFF) r_word_cnt <= r_word_cnt + 16'd1;
  end

  assign word_cnt = r_word_cnt;
`endif

endmodule

// File: tb/tb_sd_in_ddr.sv
// Randomised and directed bench for sd_in_ddr against a queue-based model of the receive FIFO.
module tb_sd_in_ddr;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       c_srdy = 1'b0;
  logic       c_drdy;
  logic [3:0] c_data = '0;
  logic       p_srdy;
  logic       p_drdy = 1'b0;
  logic [7:0] p_data;
`ifdef SD_IN_DDR_CNT_EN
  logic [15:0] word_cnt;
`endif

  sd_in_ddr #(.width(8), .depth(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .c_srdy  (c_srdy),
    .c_drdy  (c_drdy),
    .c_data  (c_data),
    .p_srdy  (p_srdy),
    .p_drdy  (p_drdy),
    .p_data  (p_data)
`ifdef SD_IN_DDR_CNT_EN
    ,
    .word_cnt(word_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the FIFO is a queue; ready after an edge is just "queue not full".
  logic [7:0] tb_word = '0;
  logic [7:0] q[$];
  logic [7:0] out_log[$];
  bit         exp_cdrdy = 0;
  int         n_push = 0;
  int         exp_cnt = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      exp_cdrdy = 0;
      exp_cnt = 0;
    end else begin
      bit push, pop;
      push = c_srdy && exp_cdrdy;
      pop  = (q.size() != 0) && p_drdy;
      if (pop) out_log.push_back(q.pop_front());
      if (push) begin
        q.push_back(tb_word);
        n_push++;
        if (exp_cnt < 65535) exp_cnt++;
      end
      exp_cdrdy = (q.size() < DEPTH);
    end
  end

  // Per-cycle comparison, away from the capturing edge.
  always @(negedge clk) begin
    chk("p_srdy", {31'd0, p_srdy}, {31'd0, q.size() != 0});
    chk("c_drdy", {31'd0, c_drdy}, {31'd0, exp_cdrdy});
    if (q.size() != 0) chk("p_data", {24'd0, p_data}, {24'd0, q[0]});
`ifdef SD_IN_DDR_CNT_EN
    chk("word_cnt", {16'd0, word_cnt}, exp_cnt);
`endif
  end

  // Called just after a posedge; drives one DDR beat and returns just after the edge that consumes it.
  task automatic step(input logic srdy, input logic [7:0] w, input logic pd);
    c_srdy = srdy;
    p_drdy = pd;
    tb_word = w;
    c_data = w[7:4];
    @(negedge clk);
    #1 c_data = w[3:0];
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 50) begin
      step(1'b0, 8'h00, 1'b1);
      guard++;
    end
    chk("drain_timeout", guard, (guard < 50) ? guard : 0);
  endtask

  initial begin
    logic [7:0] fill_w [5];
    logic [7:0] exp_w;
    int idx, cyc;
    bit acc;
    fill_w = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_p_srdy", {31'd0, p_srdy}, 32'd0);
    chk("rst_c_drdy", {31'd0, c_drdy}, 32'd0);
    chk("rst_p_data", {24'd0, p_data}, 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    chk("rel_c_drdy_low", {31'd0, c_drdy}, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_c_drdy_high", {31'd0, c_drdy}, 32'd1);

    // Single word: high half A, low half 5.
    step(1'b1, 8'hA5, 1'b1);
    chk("single_srdy", {31'd0, p_srdy}, 32'd1);
    chk("single_data", {24'd0, p_data}, 32'hA5);
    step(1'b0, 8'h00, 1'b1);
    chk("single_once", {31'd0, p_srdy}, 32'd0);

    // Fill with no consumer.
    n_push = 0;
    for (int i = 0; i < 4; i++) step(1'b1, fill_w[i], 1'b0);
    chk("fill_pushes", n_push, 32'd4);
    chk("fill_c_drdy", {31'd0, c_drdy}, 32'd0);
    step(1'b1, 8'h55, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    chk("fill_55_blocked", n_push, 32'd4);
    chk("fill_head", {24'd0, p_data}, 32'h11);
    step(1'b1, 8'h55, 1'b1);
    chk("fill_pop_rdy", {31'd0, c_drdy}, 32'd1);
    chk("fill_still_blocked", n_push, 32'd4);
    step(1'b1, 8'h55, 1'b0);
    chk("fill_55_in", n_push, 32'd5);
    for (int i = 1; i < 5; i++) begin
      chk("fill_order", {24'd0, p_data}, {24'd0, fill_w[i]});
      step(1'b0, 8'h00, 1'b1);
    end
    chk("fill_empty", {31'd0, p_srdy}, 32'd0);

    // Occupancy 3: push+pop keeps 3 and ready high; at 4 a lone pop raises ready.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h60 + 8'(i), 1'b0);
    step(1'b1, 8'h63, 1'b1);
    chk("occ3_size", q.size(), 32'd3);
    chk("occ3_rdy", {31'd0, c_drdy}, 32'd1);
    step(1'b1, 8'h64, 1'b0);
    chk("occ4_rdy", {31'd0, c_drdy}, 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("occ4_pop_rdy", {31'd0, c_drdy}, 32'd1);
    chk("occ4_pop_head", {24'd0, p_data}, 32'h62);
    drain();

    // Wrap-around with random consumer stalls.
    out_log.delete();
    idx = 0;
    cyc = 0;
    while (idx < 20 && cyc < 400) begin
      acc = exp_cdrdy;
      step(1'b1, 8'(idx), 1'($urandom_range(0, 1)));
      if (acc) idx++;
      cyc++;
    end
    chk("wrap_timeout", idx, 32'd20);
    c_srdy = 1'b0;
    drain();
    chk("wrap_len", out_log.size(), 32'd20);
    for (int i = 0; i < 20 && i < out_log.size(); i++) begin
      exp_w = 8'(i);
      chk("wrap_seq", {24'd0, out_log[i]}, {24'd0, exp_w});
    end

    // Fully random traffic.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0));
    c_srdy = 1'b0;
    drain();

    // Reset at occupancy 3.
    for (int i = 0; i < 3; i++) step(1'b1, 8'h70 + 8'(i), 1'b0);
    c_srdy = 1'b0;
    chk("pre_rst_srdy", {31'd0, p_srdy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_srdy", {31'd0, p_srdy}, 32'd0);
    chk("mid_rst_rdy", {31'd0, c_drdy}, 32'd0);
    chk("mid_rst_data", {24'd0, p_data}, 32'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_rdy", {31'd0, c_drdy}, 32'd1);
    chk("post_rst_empty", {31'd0, p_srdy}, 32'd0);
    step(1'b1, 8'hC3, 1'b1);
    chk("c3_srdy", {31'd0, p_srdy}, 32'd1);
    chk("c3_data", {24'd0, p_data}, 32'hC3);
`ifdef SD_IN_DDR_CNT_EN
    chk("cnt_after_c3", {16'd0, word_cnt}, 32'd1);
`endif
    step(1'b0, 8'h00, 1'b1);
    chk("c3_alone", {31'd0, p_srdy}, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
